// File: rtl/uj_jtag_mux.sv
// UJTAG user-DR bridge: SELECT/COMMAND registers plus a registered TCK/TMS/TDI
// bit-sequencer that fans out to one of NUM_TGT target TAPs.
//
// state   | meaning
// S_IDLE  | no command running, selected TCK low
// S_SETUP | TMS/TDI for bit idx presented, TCK low
// S_PULSE | TCK high, target TDO captured on leaving
module uj_jtag_mux #(
  parameter logic [7:0] IR_CODE = 8'h55,
  parameter int         NUM_TGT = 2,
  parameter int         SEQ_LEN = 8
) (
  input  logic               UDRCK,
  input  logic               URSTB,
  input  logic [7:0]         UIREG,
  input  logic               UDRCAP,
  input  logic               UDRSH,
  input  logic               UDRUPD,
  input  logic               UTDI,
  output logic               UTDO,
  output logic               UTDODRV,
  input  logic [NUM_TGT-1:0] TGT_TDO,
  output logic [NUM_TGT-1:0] TGT_TCK,
  output logic [NUM_TGT-1:0] TGT_TMS,
  output logic [NUM_TGT-1:0] TGT_TDI,
  output logic [NUM_TGT-1:0] TGT_TRST,
  output logic               BUSY
);

  localparam int         CW       = 2*SEQ_LEN + 4;
  localparam logic [7:0] SEL_CODE = IR_CODE + 8'd1;
  localparam logic [3:0] MAX_CNT  = 4'(SEQ_LEN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_PULSE = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [CW-1:0]      r_cmd_sr;
  logic [7:0]         r_sel_sr;
  logic [2:0]         r_sel;
  logic               r_trst;
  logic               r_overrun;
  logic [3:0]         r_count;
  logic [3:0]         r_idx;
  logic [SEQ_LEN-1:0] r_tms_v;
  logic [SEQ_LEN-1:0] r_tdi_v;
  logic [SEQ_LEN-1:0] r_tdo_cap;
  logic [NUM_TGT-1:0] r_tck;
  logic [NUM_TGT-1:0] r_tms;
  logic [NUM_TGT-1:0] r_tdi;

  logic               w_cmd_ir, w_sel_ir;
  logic               w_cmd_cap, w_cmd_sh, w_cmd_upd;
  logic               w_sel_cap, w_sel_sh, w_sel_upd;
  logic [3:0]         w_cnt_raw, w_cnt_clamp, w_idx_nxt;
  logic               w_start;
  logic [SEQ_LEN-1:0] w_tms_src, w_tdi_src;
  logic [2:0]         w_sel_nxt;
  logic               w_tck_nxt, w_tms_nxt, w_tdi_nxt;
  logic               w_tdo_sel;
  logic [CW-1:0]      w_cmd_capval;

  // Chain strobe decode; capture beats shift beats update if they ever overlap.
  assign w_cmd_ir  = (UIREG == IR_CODE);
  assign w_sel_ir  = (UIREG == SEL_CODE);
  assign w_cmd_cap = w_cmd_ir & UDRCAP;
  assign w_cmd_sh  = w_cmd_ir & UDRSH & ~UDRCAP;
  assign w_cmd_upd = w_cmd_ir & UDRUPD & ~UDRCAP & ~UDRSH;
  assign w_sel_cap = w_sel_ir & UDRCAP;
  assign w_sel_sh  = w_sel_ir & UDRSH & ~UDRCAP;
  assign w_sel_upd = w_sel_ir & UDRUPD & ~UDRCAP & ~UDRSH;

  assign UTDODRV  = w_cmd_ir | w_sel_ir;
  assign UTDO     = w_cmd_ir ? r_cmd_sr[0] : (w_sel_ir & r_sel_sr[0]);
  assign BUSY     = (r_state != S_IDLE);
  assign TGT_TCK  = r_tck;
  assign TGT_TMS  = r_tms;
  assign TGT_TDI  = r_tdi;
  assign TGT_TRST = {NUM_TGT{r_trst}};

  assign w_cnt_raw    = r_cmd_sr[3:0];
  assign w_cnt_clamp  = (w_cnt_raw > MAX_CNT) ? MAX_CNT : w_cnt_raw;
  assign w_start      = w_cmd_upd & ~BUSY & (w_cnt_raw != 4'd0);
  assign w_tms_src    = w_start ? r_cmd_sr[SEQ_LEN+3:4] : r_tms_v;
  assign w_tdi_src    = w_start ? r_cmd_sr[2*SEQ_LEN+3:SEQ_LEN+4] : r_tdi_v;
  assign w_sel_nxt    = (w_sel_upd & ~BUSY) ? r_sel_sr[2:0] : r_sel;
  assign w_cmd_capval = {{SEQ_LEN{1'b0}}, r_tdo_cap, 2'b00, r_overrun, BUSY};

  always_ff @(posedge UDRCK or negedge URSTB) begin
    if (!URSTB) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_SETUP;
          w_idx_nxt   = 4'd0;
        end
      end
      S_SETUP: w_state_nxt = S_PULSE;
      S_PULSE: begin
        w_idx_nxt   = r_idx + 4'd1;
        w_state_nxt = (r_idx + 4'd1 == r_count) ? S_IDLE : S_SETUP;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pin values are computed from the next state so the pins themselves are flops.
  always_comb begin
    w_tck_nxt = 1'b0;
    w_tms_nxt = 1'b1;
    w_tdi_nxt = 1'b0;
    if (w_state_nxt != S_IDLE) begin
      w_tck_nxt = (w_state_nxt == S_PULSE);
      for (int j = 0; j < SEQ_LEN; j++) begin
        if (w_idx_nxt == 4'(j)) begin
          w_tms_nxt = w_tms_src[j];
          w_tdi_nxt = w_tdi_src[j];
        end
      end
    end
  end

  always_comb begin
    w_tdo_sel = 1'b0;
    for (int k = 0; k < NUM_TGT; k++) begin
      if (r_sel == 3'(k)) w_tdo_sel = TGT_TDO[k];
    end
  end

  always_ff @(posedge UDRCK or negedge URSTB) begin
    if (!URSTB) begin
      r_tck <= '0;
      r_tms <= '1;
      r_tdi <= '0;
    end else begin
      for (int k = 0; k < NUM_TGT; k++) begin
        r_tck[k] <= (w_sel_nxt == 3'(k)) & w_tck_nxt;
        r_tms[k] <= (w_sel_nxt == 3'(k)) ? w_tms_nxt : 1'b1;
        r_tdi[k] <= (w_sel_nxt == 3'(k)) & w_tdi_nxt;
      end
    end
  end

  always_ff @(posedge UDRCK or negedge URSTB) begin
    if (!URSTB) begin
      r_count   <= '0;
      r_idx     <= '0;
      r_tms_v   <= '0;
      r_tdi_v   <= '0;
      r_tdo_cap <= '0;
    end else begin
      r_idx <= w_idx_nxt;
      if (w_start) begin
        r_count   <= w_cnt_clamp;
        r_tms_v   <= w_tms_src;
        r_tdi_v   <= w_tdi_src;
        r_tdo_cap <= '0;
      end else if (r_state == S_PULSE) begin
        for (int j = 0; j < SEQ_LEN; j++) begin
          if (r_idx == 4'(j)) r_tdo_cap[j] <= w_tdo_sel;
        end
      end
    end
  end

  always_ff @(posedge UDRCK or negedge URSTB) begin
    if (!URSTB) begin
      r_cmd_sr  <= '0;
      r_sel_sr  <= '0;
      r_sel     <= '0;
      r_trst    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_cmd_cap) begin
        r_cmd_sr <= w_cmd_capval;
      end else if (w_cmd_sh) begin
        r_cmd_sr <= {UTDI, r_cmd_sr[CW-1:1]};
      end

      if (w_sel_cap) begin
        r_sel_sr <= {r_trst, 4'b0000, r_sel};
      end else if (w_sel_sh) begin
        r_sel_sr <= {UTDI, r_sel_sr[7:1]};
      end

      if (w_sel_upd & ~BUSY) begin
        r_sel  <= r_sel_sr[2:0];
        r_trst <= r_sel_sr[7];
      end

      // Sticky until read: any update that lands while busy is dropped.
      if (w_cmd_cap) begin
        r_overrun <= 1'b0;
      end else if ((w_cmd_upd | w_sel_upd) & BUSY) begin
        r_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uj_jtag_mux.sv
// Directed bench for uj_jtag_mux: table of SELECT/COMMAND scans with expected
// pulse trains and read-back, plus overrun and mid-sequence reset sequences.
module tb_uj_jtag_mux;

  logic       UDRCK = 1'b0;
  logic       URSTB;
  logic [7:0] UIREG;
  logic       UDRCAP, UDRSH, UDRUPD, UTDI;
  logic       UTDO, UTDODRV;
  logic [1:0] TGT_TDO, TGT_TCK, TGT_TMS, TGT_TDI, TGT_TRST;
  logic       BUSY;

  int n_checks = 0;
  int n_fail   = 0;

  uj_jtag_mux #(.IR_CODE(8'h55), .NUM_TGT(2), .SEQ_LEN(8)) dut (
    .UDRCK(UDRCK), .URSTB(URSTB), .UIREG(UIREG),
    .UDRCAP(UDRCAP), .UDRSH(UDRSH), .UDRUPD(UDRUPD), .UTDI(UTDI),
    .UTDO(UTDO), .UTDODRV(UTDODRV),
    .TGT_TDO(TGT_TDO), .TGT_TCK(TGT_TCK), .TGT_TMS(TGT_TMS),
    .TGT_TDI(TGT_TDI), .TGT_TRST(TGT_TRST), .BUSY(BUSY)
  );

  always #5 UDRCK = ~UDRCK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] sel;
    logic [3:0] cnt;
    logic [7:0] tms;
    logic [7:0] tdi;
    logic [7:0] pat;
    int         exp_p0;
    int         exp_p1;
    int         exp_busy;
    logic [7:0] exp_tms;
    logic [7:0] exp_tdi;
    logic [7:0] exp_cap;
    logic [7:0] exp_sel_rb;
    logic       exp_trst;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Capture, shift n bits LSB-first (collecting UTDO), optional update.
  task automatic dr_scan(input logic [7:0] ir, input logic [19:0] din, input int n,
                         output logic [19:0] dout, input logic upd);
    dout   = '0;
    UIREG  = ir;
    UDRCAP = 1'b1;
    @(negedge UDRCK);
    UDRCAP = 1'b0;
    for (int i = 0; i < n; i++) begin
      UDRSH   = 1'b1;
      UTDI    = din[i];
      dout[i] = UTDO;
      @(negedge UDRCK);
    end
    UDRSH  = 1'b0;
    UDRUPD = upd;
    @(negedge UDRCK);
    UDRUPD = 1'b0;
  endtask

  // Observe a fixed window; optionally fire a bare COMMAND update at cycle extra_at.
  task automatic run_seq(input logic [7:0] pat, input int extra_at,
                         output int busy_cnt, output int p0, output int p1,
                         output logic [7:0] otms, output logic [7:0] otdi);
    logic [1:0] prev;
    int np;
    prev = 2'b00; np = 0; busy_cnt = 0; p0 = 0; p1 = 0; otms = '0; otdi = '0;
    TGT_TDO = {2{pat[0]}};
    for (int c = 0; c < 40; c++) begin
      if (BUSY) busy_cnt++;
      for (int ch = 0; ch < 2; ch++) begin
        if (TGT_TCK[ch] && !prev[ch]) begin
          if (ch == 0) p0++; else p1++;
          if (np < 8) begin
            otms[np[2:0]] = TGT_TMS[ch];
            otdi[np[2:0]] = TGT_TDI[ch];
            TGT_TDO       = {2{pat[np[2:0]]}};
          end
          np++;
        end
      end
      prev   = TGT_TCK;
      UDRUPD = (c == extra_at);
      @(negedge UDRCK);
    end
    UDRUPD = 1'b0;
    chk("seq_end_busy", BUSY, 1'b0);
  endtask

  initial begin
    logic [19:0] rb;
    logic [7:0]  otms, otdi;
    int          busy_cnt, p0, p1, np;
    logic        prev1, found;
    logic [7:0]  ir_v[4];
    logic        drv_v[4];

    tbl[0] = '{8'h01, 4'd5,  8'h1F, 8'h00, 8'h00, 0, 5, 10, 8'h1F, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[1] = '{8'h00, 4'd4,  8'h00, 8'h0A, 8'h0D, 4, 0, 8,  8'h00, 8'h0A, 8'h0D, 8'h01, 1'b0};
    tbl[2] = '{8'h87, 4'd3,  8'hFF, 8'hFF, 8'hFF, 0, 0, 6,  8'h00, 8'h00, 8'h00, 8'h00, 1'b1};
    tbl[3] = '{8'h00, 4'd15, 8'hA5, 8'h3C, 8'h96, 8, 0, 16, 8'hA5, 8'h3C, 8'h96, 8'h87, 1'b0};
    tbl[4] = '{8'h01, 4'd0,  8'hFF, 8'hFF, 8'h00, 0, 0, 0,  8'h00, 8'h00, 8'h96, 8'h00, 1'b0};
    tbl[5] = '{8'h01, 4'd1,  8'h01, 8'h01, 8'h01, 0, 1, 2,  8'h01, 8'h01, 8'h01, 8'h01, 1'b0};

    ir_v[0] = 8'h55; drv_v[0] = 1'b1;
    ir_v[1] = 8'h56; drv_v[1] = 1'b1;
    ir_v[2] = 8'h57; drv_v[2] = 1'b0;
    ir_v[3] = 8'h54; drv_v[3] = 1'b0;

    URSTB = 1'b0; UIREG = 8'h00; UDRCAP = 1'b0; UDRSH = 1'b0; UDRUPD = 1'b0;
    UTDI = 1'b0; TGT_TDO = 2'b00;
    repeat (3) @(negedge UDRCK);
    URSTB = 1'b1;
    @(negedge UDRCK);
    chk("rst_tms", TGT_TMS, 2'b11);
    chk("rst_tck", TGT_TCK, 2'b00);
    chk("rst_tdi", TGT_TDI, 2'b00);
    chk("rst_trst", TGT_TRST, 2'b00);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_utdodrv", UTDODRV, 1'b0);
    chk("rst_utdo", UTDO, 1'b0);

    for (int i = 0; i < 4; i++) begin
      UIREG = ir_v[i];
      #1;
      chk($sformatf("utdodrv_%0h", ir_v[i]), UTDODRV, drv_v[i]);
    end
    UIREG = 8'h00;
    @(negedge UDRCK);

    for (int i = 0; i < 6; i++) begin
      dr_scan(8'h56, {12'h000, tbl[i].sel}, 8, rb, 1'b1);
      chk($sformatf("r%0d_sel_rb", i), rb[7:0], tbl[i].exp_sel_rb);
      chk($sformatf("r%0d_trst", i), TGT_TRST, {2{tbl[i].exp_trst}});
      dr_scan(8'h55, {tbl[i].tdi, tbl[i].tms, tbl[i].cnt}, 20, rb, 1'b1);
      run_seq(tbl[i].pat, -1, busy_cnt, p0, p1, otms, otdi);
      chk($sformatf("r%0d_busy_cycles", i), busy_cnt, tbl[i].exp_busy);
      chk($sformatf("r%0d_pulses_ch0", i), p0, tbl[i].exp_p0);
      chk($sformatf("r%0d_pulses_ch1", i), p1, tbl[i].exp_p1);
      chk($sformatf("r%0d_tms_seq", i), otms, tbl[i].exp_tms);
      chk($sformatf("r%0d_tdi_seq", i), otdi, tbl[i].exp_tdi);
      chk($sformatf("r%0d_idle_tms", i), TGT_TMS, 2'b11);
      dr_scan(8'h55, 20'h0, 20, rb, 1'b0);
      chk($sformatf("r%0d_tdo_cap", i), rb[11:4], tbl[i].exp_cap);
      chk($sformatf("r%0d_overrun", i), rb[1], 1'b0);
      chk($sformatf("r%0d_cap_busy", i), rb[0], 1'b0);
      chk($sformatf("r%0d_cap_upper", i), rb[19:12], 8'h00);
    end

    // Second COMMAND update mid-run is dropped and flagged.
    dr_scan(8'h55, {8'hFF, 8'h00, 4'd8}, 20, rb, 1'b1);
    run_seq(8'hAA, 3, busy_cnt, p0, p1, otms, otdi);
    chk("ovr_busy_cycles", busy_cnt, 16);
    chk("ovr_pulses_ch1", p1, 8);
    chk("ovr_pulses_ch0", p0, 0);
    chk("ovr_tdi_seq", otdi, 8'hFF);
    chk("ovr_tms_seq", otms, 8'h00);
    dr_scan(8'h55, 20'h0, 20, rb, 1'b0);
    chk("ovr_flag_set", rb[1], 1'b1);
    chk("ovr_tdo_cap", rb[11:4], 8'hAA);
    dr_scan(8'h55, 20'h0, 20, rb, 1'b0);
    chk("ovr_flag_cleared", rb[1], 1'b0);

    // Reset during the third pulse (idx=2) aborts the run.
    dr_scan(8'h55, {8'h00, 8'hFF, 4'd8}, 20, rb, 1'b1);
    np = 0; prev1 = 1'b0; found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (TGT_TCK[1] && !prev1) begin
        if (np == 2) begin
          URSTB = 1'b0;
          #1;
          found = 1'b1;
          chk("arst_tck", TGT_TCK, 2'b00);
          chk("arst_busy", BUSY, 1'b0);
          chk("arst_tms", TGT_TMS, 2'b11);
          chk("arst_tdi", TGT_TDI, 2'b00);
        end
        np++;
      end
      prev1 = TGT_TCK[1];
      if (!found) @(negedge UDRCK);
    end
    chk("arst_reached_pulse2", found, 1'b1);
    URSTB = 1'b0;
    repeat (2) @(negedge UDRCK);
    URSTB = 1'b1;
    run_seq(8'h00, -1, busy_cnt, p0, p1, otms, otdi);
    chk("arst_after_busy", busy_cnt, 0);
    chk("arst_after_pulses", p0 + p1, 0);
    dr_scan(8'h56, 20'h0, 8, rb, 1'b0);
    chk("arst_sel_rb", rb[7:0], 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
